ring_arbiter: RTL
=================

# ring_arbiter

Round-robin arbiter that shares one resource among N requesters using a one-hot ring-counter priority pointer. Each requester holds `req` high for as long as it needs the resource. The arbiter issues a registered one-hot grant and rotates priority past the winner on release. It sits in front of any shared datapath, such as a counter or bus, and sequences ownership of it so that no requester starves.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_HOLD`, default 8: maximum grant length in cycles. Used only when the timeout feature is compiled in; legal range 2..255.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset. Asserting it (low) clears all state immediately; state is released on the first `clk` edge after it goes high.
- `req`  input  N: request vector. Bit i high means requester i wants the resource or is still using it.
- `gnt`  output  N: registered one-hot grant, or all zeros.
- `gnt_id`  output  $clog2(N): binary index of the granted requester. Value is 0 when `gnt` is 0.
- `busy`  output  1: high while in the GRANT state.
- `timeout`  output  1: one-cycle pulse when a grant is forcibly revoked. Constant 0 when the feature is compiled out.

## Operation
- Priority pointer `ptr`, N bits, is one-hot; reset value is `1` (bit 0).
- The search order starts at the set bit of `ptr` and proceeds circularly upward: ptr, ptr+1, …, N-1, 0, … The first asserted `req` bit in that order is the winner.
- The FSM has two states, IDLE and GRANT; reset state is IDLE.
- IDLE:
  - `req` == 0: stay in IDLE; outputs remain 0.
  - `req` != 0: go to GRANT with `gnt` = one-hot of the winner and `gnt_id` = winner index. `ptr` is unchanged.
- GRANT with holder g:
  - `req[g]` high: stay in GRANT; `gnt` and `gnt_id` hold. Requests from other requesters are ignored, so there is no preemption.
  - `req[g]` low: go to IDLE, clear `gnt`/`gnt_id` to 0, and rotate `ptr` to one-hot bit (g+1) mod N.
- Wrap-around: if g = N-1 releases, `ptr` returns to bit 0.
- A requester that drops and reasserts `req` while another requester is waiting goes to the back of the rotation.
- Reset asserted mid-grant: `gnt` drops to 0 asynchronously, and `ptr` returns to bit 0. Any pending grant is lost; requesters must still be requesting after reset is released to be served.
- `req` bits are sampled only at the clock edge; glitches between edges have no effect.

## Timing
- Reset values: `gnt` = 0, `gnt_id` = 0, `busy` = 0, `timeout` = 0, `ptr` = 1, state = IDLE.
- Grant latency: `req` sampled high in IDLE at edge k, `gnt` is high after edge k (1 cycle).
- Release latency: `req[g]` sampled low at edge k, `gnt` is low after edge k.
- Re-arbitration: the earliest new grant appears after edge k+1. There is therefore always at least one gnt = 0 bubble cycle between consecutive grants.
- Worst-case wait for a continuously requesting requester: (N-1) grants, each plus one bubble cycle. With the timeout feature compiled in, this bound is (N-1)·(MAX_HOLD+1) cycles.
- `busy` equals |gnt at every cycle.

## Configuration
- Macro: `RING_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments on each cycle spent in GRANT.
  - When `gnt` has been high for MAX_HOLD consecutive cycles and `req[g]` is still high, the arbiter forces GRANT→IDLE and rotates `ptr` exactly as for a normal release.
  - `timeout` pulses high for the same single cycle in which `gnt` first reads 0.
  - If `req[g]` drops on the same edge the limit is reached, this is a normal release and `timeout` stays 0.
- Undefined: the counter is absent, grants last indefinitely, and `timeout` is tied to 0.

## Test plan
- Reset/idle:
  - Hold `reset` = 0 → `gnt` = 0000, `busy` = 0, `ptr` = 0001.
  - Release reset with `req` = 0000 for 5 cycles → outputs stay 0.
- Single requester:
  - Assert `req` = 0100 → `gnt` = 0100 and `gnt_id` = 2 one cycle later.
  - Drop `req` → `gnt` = 0000 next cycle, and `ptr` = 1000.
- Round-robin fairness, N = 4:
  - Hold `req` = 1111, and have each holder release after 2 cycles then reassert.
  - Required grant order: 0001, 0010, 0100, 1000, 0001, with exactly one 0000 bubble between grants.
- Wrap and skip:
  - Start with `ptr` = 1000 and `req` = 0011 → `gnt` = 0001.
  - After release, with `req` = 0010 → `gnt` = 0010.
- Reset mid-grant: with `gnt` = 0010, pull `reset` low asynchronously between edges → `gnt` = 0000 immediately and `ptr` = 0001.
- Timeout, macro defined, MAX_HOLD = 8:
  - Hold `req` = 0011 → `gnt` = 0001 for exactly 8 cycles.
  - Then `gnt` = 0000 with a one-cycle `timeout` pulse.
  - Then `gnt` = 0010.
  - With the macro undefined, the same stimulus keeps `gnt` = 0001 indefinitely.

Source files
------------

// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin arbiter with a one-hot ring-counter priority pointer.
//
// A requester holds req high for as long as it owns the resource. The arbiter
// issues a registered one-hot grant, never preempts, and rotates the priority
// pointer to the requester after the holder when the grant is released. There
// is always at least one gnt = 0 bubble cycle between consecutive grants.
//
// Optional feature: define RING_ARB_TIMEOUT_EN to revoke a grant that has been
// held for MAX_HOLD consecutive cycles. When undefined, grants last until the
// holder drops req and timeout is constant 0.
//
// Ports:
//   clk     in  1             rising-edge clock
//   reset   in  1             asynchronous active-low reset
//   req     in  N             request vector, bit i = requester i
//   gnt     out N             registered one-hot grant, or all zeros
//   gnt_id  out $clog2(N)     index of granted requester, 0 when gnt is 0
//   busy    out 1             high while a grant is held (equals |gnt)
//   timeout out 1             one-cycle pulse when a grant is forcibly revoked
module ring_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Elaboration-time guard on the legal parameter ranges.
    if (N < 2 || N > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("ring_arbiter: N must be 2..16 and MAX_HOLD 2..255");
    end

    state_t         state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] ptr_idx_s;
    logic [N-1:0]   req_rot_s;
    logic [IDW-1:0] win_off_s;
    logic [IDW:0]   win_sum_s;
    logic [IDW-1:0] win_idx_s;
    logic [IDW-1:0] next_idx_s;
    logic           holder_req_s;
    logic           release_s;
    logic           force_s;

    // Convert the one-hot pointer to its binary index.
    always_comb begin
        ptr_idx_s = {IDW{1'b0}};
        for (int i = 0; i < N; i++) begin
            ptr_idx_s = ptr_idx_s | (ptr_q[i] ? IDW'(i) : {IDW{1'b0}});
        end
    end

    // Rotate req so the pointer position lands at bit 0; the lowest set bit
    // of the rotated vector is then the winner's offset from the pointer.
    assign req_rot_s = N'({req, req} >> ptr_idx_s);

    // Lowest-set-bit search over the rotated request vector.
    always_comb begin
        win_off_s = {IDW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            win_off_s = req_rot_s[k] ? IDW'(k) : win_off_s;
        end
    end

    // Winner index = (pointer + offset) mod N.
    assign win_sum_s  = {1'b0, ptr_idx_s} + {1'b0, win_off_s};
    assign win_idx_s  = (win_sum_s >= (IDW+1)'(N)) ? IDW'(win_sum_s - (IDW+1)'(N))
                                                   : IDW'(win_sum_s);
    assign next_idx_s = (gnt_id_q == IDW'(N - 1)) ? {IDW{1'b0}} : gnt_id_q + IDW'(1);
    assign holder_req_s = req[gnt_id_q];

`ifdef RING_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    // Hold counter: zero while idle so it starts at 0 on grant entry, then
    // counts cycles spent in GRANT.
    always_comb begin
        if (state_q == GRANT) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
            hold_cnt_d = 8'd0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // The counter reads MAX_HOLD-1 at the edge that ends the MAX_HOLD-th
    // grant cycle; revoke only if the holder is still requesting.
    assign force_s = (state_q == GRANT) && holder_req_s &&
                     (hold_cnt_q == 8'(MAX_HOLD - 1));
`else
    assign force_s = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= ONE_HOT0;
            gnt_q     <= {N{1'b0}};
            gnt_id_q  <= {IDW{1'b0}};
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and pointer rotation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        release_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!holder_req_s || force_s) begin
                    state_d   = IDLE;
                    ptr_d     = ONE_HOT0 << next_idx_s;
                    release_s = 1'b1;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = ONE_HOT0 << win_idx_s;
                    gnt_id_d = win_idx_s;
                end else begin
                    gnt_d    = {N{1'b0}};
                    gnt_id_d = {IDW{1'b0}};
                end
            end
            GRANT: begin
                if (release_s) begin
                    gnt_d     = {N{1'b0}};
                    gnt_id_d  = {IDW{1'b0}};
                    timeout_d = force_s;
                end else begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
                end
            end
            default: begin
                gnt_d    = {N{1'b0}};
                gnt_id_d = {IDW{1'b0}};
            end
        endcase
        busy_d = |gnt_d;
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
